core_debug_controller: RTL and testbench

//  Host-side debug/run controller for the rv32i core. Sits between a command port (UART bridge or
//  AXI slave) and the core's cm_* control pins. Sequences halt/resume/single-step, exposes PC and

---
 rtl/core_debug_controller.sv | 210 +++++++++++++++++++++
 tb/tb_core_debug_controller.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_debug_controller.sv
// Host-side debug/run controller for the rv32i core: sequences halt, resume and single-step,
// gives PC and register-file access while halted, and provides one hardware PC breakpoint.
module core_debug_controller #(
    parameter bit RESET_HALTED   = 1'b1,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [2:0]                cmd_op_i,
    input  logic [REG_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATA_WIDTH-1:0]     rsp_data_o,
    output logic                      rsp_err_o,
    input  logic                      core_idle_i,
    input  logic [DATA_WIDTH-1:0]     cm_pc_read_data_i,
    output logic                      cm_pc_stall_o,
    output logic                      cm_pc_we_o,
    output logic [DATA_WIDTH-1:0]     cm_pc_write_data_o,
    output logic [REG_ADDR_WIDTH-1:0] cm_regfile_addr_o,
    input  logic [DATA_WIDTH-1:0]     cm_regfile_read_data_i,
    output logic                      cm_regfile_we_o,
    output logic [DATA_WIDTH-1:0]     cm_regfile_write_data_o,
    output logic                      dbg_halted_o,
    output logic [1:0]                dbg_halt_cause_o
);

    typedef enum logic [2:0] {
        S_RUNNING, S_HALTING, S_HALTED, S_STEP_REL, S_STEP_WAIT, S_ACCESS, S_RESP
    } state_e;

    typedef enum logic [2:0] {
        OP_SET_BP, OP_HALT, OP_RESUME, OP_STEP, OP_RD_PC, OP_WR_PC, OP_RD_REG, OP_WR_REG
    } op_e;

    typedef enum logic [1:0] {
        CAUSE_RESET, CAUSE_HALT, CAUSE_STEP, CAUSE_BP
    } cause_e;

    localparam state_e RESET_STATE = RESET_HALTED ? S_HALTED : S_RUNNING;

    state_e                      state_q;
    cause_e                      cause_q;
    logic                        rsp_valid_q;
    logic                        rsp_err_q;
    logic [DATA_WIDTH-1:0]       rsp_data_q;
    logic                        bp_en_q;
    logic [DATA_WIDTH-1:0]       bp_addr_q;
    logic                        bp_skip_q;
    logic                        pc_we_q;
    logic [DATA_WIDTH-1:0]       pc_wdata_q;
    logic                        rf_we_q;
    logic [DATA_WIDTH-1:0]       rf_wdata_q;
    logic [REG_ADDR_WIDTH-1:0]   rf_addr_q;

    op_e  op;
    logic cmd_accept;
    logic bp_hit;

    assign op          = op_e'(cmd_op_i);
    assign cmd_ready_o = (state_q == S_RUNNING || state_q == S_HALTED) && !rsp_valid_q;
    assign cmd_accept  = cmd_valid_i && cmd_ready_o;

    // The breakpoint must block the PC in the very cycle it becomes visible, so it bypasses the register.
    assign bp_hit = (state_q == S_RUNNING) && core_idle_i && bp_en_q && !bp_skip_q
                    && (cm_pc_read_data_i == bp_addr_q);

    assign cm_pc_stall_o           = !(state_q == S_RUNNING || state_q == S_STEP_REL) || bp_hit;
    assign cm_pc_we_o              = pc_we_q;
    assign cm_pc_write_data_o      = pc_wdata_q;
    assign cm_regfile_addr_o       = rf_addr_q;
    assign cm_regfile_we_o         = rf_we_q;
    assign cm_regfile_write_data_o = rf_wdata_q;
    assign rsp_valid_o             = rsp_valid_q;
    assign rsp_err_o               = rsp_err_q;
    assign rsp_data_o              = rsp_data_q;
    assign dbg_halted_o            = (state_q == S_HALTED);
    assign dbg_halt_cause_o        = cause_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RESET_STATE;
            cause_q     <= CAUSE_RESET;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            bp_en_q     <= 1'b0;
            bp_addr_q   <= '0;
            bp_skip_q   <= 1'b0;
            pc_we_q     <= 1'b0;
            pc_wdata_q  <= '0;
            rf_we_q     <= 1'b0;
            rf_wdata_q  <= '0;
            rf_addr_q   <= '0;
        end else begin
            pc_we_q <= 1'b0;
            rf_we_q <= 1'b0;
            // Once the core has left the breakpoint PC the skip is no longer needed.
            if (!core_idle_i) begin
                bp_skip_q <= 1'b0;
            end
            if (rsp_valid_q && rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
                rsp_err_q   <= 1'b0;
                rsp_data_q  <= '0;
            end

            case (state_q)
                S_RUNNING: begin
                    if (cmd_accept) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= !(op == OP_SET_BP || op == OP_HALT || op == OP_RESUME);
                        if (op == OP_SET_BP) begin
                            bp_addr_q <= cmd_wdata_i;
                            bp_en_q   <= cmd_addr_i[0];
                        end
                        if (op == OP_HALT && !bp_hit) begin
                            rsp_valid_q <= 1'b0;
                            state_q     <= S_HALTING;
                        end
                    end
                    if (bp_hit) begin
                        state_q <= S_HALTED;
                        cause_q <= CAUSE_BP;
                    end
                end
                S_HALTED: begin
                    if (cmd_accept) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= '0;
                        case (op)
                            OP_SET_BP: begin
                                bp_addr_q <= cmd_wdata_i;
                                bp_en_q   <= cmd_addr_i[0];
                            end
                            OP_HALT: begin
                            end
                            OP_RESUME: begin
                                bp_skip_q <= 1'b1;
                                state_q   <= S_RUNNING;
                            end
                            OP_STEP: begin
                                rsp_valid_q <= 1'b0;
                                bp_skip_q   <= 1'b1;
                                state_q     <= S_STEP_REL;
                            end
                            OP_RD_PC: rsp_data_q <= cm_pc_read_data_i;
                            OP_WR_PC: begin
                                pc_we_q    <= 1'b1;
                                pc_wdata_q <= cmd_wdata_i;
                            end
                            OP_RD_REG: begin
                                rsp_valid_q <= 1'b0;
                                rf_addr_q   <= cmd_addr_i;
                                state_q     <= S_ACCESS;
                            end
                            OP_WR_REG: begin
                                rf_addr_q  <= cmd_addr_i;
                                rf_wdata_q <= cmd_wdata_i;
                                rf_we_q    <= 1'b1;
                            end
                        endcase
                    end
                end
                S_HALTING: begin
                    if (core_idle_i) begin
                        state_q     <= S_HALTED;
                        cause_q     <= CAUSE_HALT;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= '0;
                    end
                end
                S_STEP_REL: begin
                    if (!core_idle_i) begin
                        state_q <= S_STEP_WAIT;
                    end
                end
                S_STEP_WAIT: begin
                    if (core_idle_i) begin
                        state_q     <= S_HALTED;
                        cause_q     <= CAUSE_STEP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= cm_pc_read_data_i;
                    end
                end
                S_ACCESS: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= cm_regfile_read_data_i;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= S_HALTED;
                    end
                end
                default: state_q <= RESET_STATE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_debug_controller.sv
// Self-checking bench for core_debug_controller: a small behavioural core and register file
// respond to the cm_* pins while commands are checked against a reference model.
module tb_core_debug_controller;

    localparam logic [31:0] BOOT_ADDR = 32'h0000_0080;
    localparam int          CORE_LAT  = 2;
    localparam int          TIMEOUT   = 200;
    localparam logic [2:0]  OP_SET_BP = 3'd0, OP_HALT = 3'd1, OP_RESUME = 3'd2, OP_STEP = 3'd3,
                            OP_RD_PC  = 3'd4, OP_WR_PC = 3'd5, OP_RD_REG = 3'd6, OP_WR_REG = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmdValid, cmdReady, rspValid, rspReady, rspErr;
    logic [2:0]  cmdOp;
    logic [4:0]  cmdAddr, cmRfAddr;
    logic [31:0] cmdWdata, rspData;
    logic        coreIdle, cmPcStall, cmPcWe, cmRfWe, dbgHalted;
    logic [31:0] pcRead, cmPcWdata, cmRfRdata, cmRfWdata;
    logic [1:0]  dbgCause;

    int checks = 0;
    int failures = 0;

    logic [31:0] expRf [32];
    logic [31:0] expPc;

    core_debug_controller #(.RESET_HALTED(1'b1), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady), .cmd_op_i(cmdOp),
        .cmd_addr_i(cmdAddr), .cmd_wdata_i(cmdWdata),
        .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_data_o(rspData), .rsp_err_o(rspErr),
        .core_idle_i(coreIdle), .cm_pc_read_data_i(pcRead), .cm_pc_stall_o(cmPcStall),
        .cm_pc_we_o(cmPcWe), .cm_pc_write_data_o(cmPcWdata),
        .cm_regfile_addr_o(cmRfAddr), .cm_regfile_read_data_i(cmRfRdata),
        .cm_regfile_we_o(cmRfWe), .cm_regfile_write_data_o(cmRfWdata),
        .dbg_halted_o(dbgHalted), .dbg_halt_cause_o(dbgCause)
    );

    always #5 clk = ~clk;

    // Behavioural core: an idle, unstalled PC is released, runs CORE_LAT+1 cycles, then advances by 4.
    // In manual mode the bench drives core_idle and the PC directly.
    logic        autoMode, manIdle, modelIdle;
    logic [31:0] manPc, modelPc;
    int          modelBusy, relAtBp;

    assign coreIdle = autoMode ? modelIdle : manIdle;
    assign pcRead   = autoMode ? modelPc : manPc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelPc   <= BOOT_ADDR;
            modelIdle <= 1'b1;
            modelBusy <= 0;
            relAtBp   <= 0;
        end else if (cmPcWe) begin
            modelPc <= cmPcWdata;
        end else if (autoMode) begin
            if (modelIdle && !cmPcStall) begin
                modelIdle <= 1'b0;
                modelBusy <= CORE_LAT;
                if (modelPc == 32'h10C) relAtBp <= relAtBp + 1;
            end else if (!modelIdle) begin
                if (modelBusy == 0) begin
                    modelIdle <= 1'b1;
                    modelPc   <= modelPc + 32'd4;
                end else begin
                    modelBusy <= modelBusy - 1;
                end
            end
        end
    end

    // Register file that ignores writes to x0, plus pulse counters for the write strobes.
    logic [31:0] tbRf [32];
    int rfWeCnt = 0;
    int pcWeCnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) tbRf[i] <= '0;
        end else if (cmRfWe && cmRfAddr != 5'd0) begin
            tbRf[cmRfAddr] <= cmRfWdata;
        end
    end
    assign cmRfRdata = tbRf[cmRfAddr];

    always @(posedge clk) begin
        if (cmRfWe) rfWeCnt <= rfWeCnt + 1;
        if (cmPcWe) pcWeCnt <= pcWeCnt + 1;
    end

    // Issue one command, wait (bounded) for its response, hold rsp_ready low rdyDelay cycles, then take it.
    task automatic send_cmd(input logic [2:0] op, input logic [4:0] addr, input logic [31:0] wd,
                            input int rdyDelay, output logic [31:0] data, output logic err,
                            output logic timedOut);
        int n;
        data = '0; err = 1'b0; timedOut = 1'b0;
        @(negedge clk);
        cmdValid = 1'b1; cmdOp = op; cmdAddr = addr; cmdWdata = wd;
        n = 0;
        while (!cmdReady && n < TIMEOUT) begin @(negedge clk); n++; end
        if (!cmdReady) begin cmdValid = 1'b0; timedOut = 1'b1; return; end
        @(negedge clk);
        cmdValid = 1'b0;
        n = 0;
        while (!rspValid && n < TIMEOUT) begin @(negedge clk); n++; end
        if (!rspValid) begin timedOut = 1'b1; return; end
        repeat (rdyDelay) @(negedge clk);
        data = rspData; err = rspErr;
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e, t;
        rst_n = 1'b0; cmdValid = 1'b0; cmdOp = '0; cmdAddr = '0; cmdWdata = '0; rspReady = 1'b0;
        autoMode = 1'b1; manIdle = 1'b1; manPc = '0;
        for (int i = 0; i < 32; i++) expRf[i] = '0;
        expPc = BOOT_ADDR;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmPcStall, dbgHalted, dbgCause, rspValid, rspErr, cmdReady, cmPcWe, cmRfWe} !== 9'b1_1_00_0_0_1_0_0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got stall=%b halted=%b cause=%0d rv=%b err=%b crdy=%b pcwe=%b rfwe=%b want 1 1 0 0 0 1 0 0",
                     cmPcStall, dbgHalted, dbgCause, rspValid, rspErr, cmdReady, cmPcWe, cmRfWe);
        end
        send_cmd(OP_RD_PC, 5'd0, 32'd0, 0, d, e, t);
        checks++;
        if ({t, e, d} !== {2'b00, BOOT_ADDR}) begin
            failures++; $display("[TB] FAIL reset_rd_pc: got to=%b err=%b data=%h want 0 0 %h", t, e, d, BOOT_ADDR);
        end
    endtask

    task automatic test_reg_access();
        logic [31:0] d; logic e, t; int n0;
        n0 = rfWeCnt;
        send_cmd(OP_WR_REG, 5'd5, 32'hDEADBEEF, 0, d, e, t);
        expRf[5] = 32'hDEADBEEF;
        checks++;
        if ({t, e, d} !== 34'd0) begin
            failures++; $display("[TB] FAIL wr_reg_rsp: got to=%b err=%b data=%h want 0 0 0", t, e, d);
        end
        checks++;
        if (rfWeCnt - n0 !== 1) begin
            failures++; $display("[TB] FAIL wr_reg_we_cycles: got %0d want 1", rfWeCnt - n0);
        end
        send_cmd(OP_RD_REG, 5'd5, 32'd0, 0, d, e, t);
        checks++;
        if ({t, e, d} !== {2'b00, expRf[5]}) begin
            failures++; $display("[TB] FAIL rd_reg_x5: got to=%b err=%b data=%h want 0 0 %h", t, e, d, expRf[5]);
        end
        send_cmd(OP_WR_REG, 5'd0, 32'h1234_5678, 0, d, e, t);
        send_cmd(OP_RD_REG, 5'd0, 32'd0, 0, d, e, t);
        checks++;
        if ({t, e, d} !== 34'd0) begin
            failures++; $display("[TB] FAIL rd_reg_x0: got to=%b err=%b data=%h want 0 0 0", t, e, d);
        end
    endtask

    task automatic test_random_halted(input int count);
        logic [31:0] d, wd, expData; logic e, t; logic [2:0] op; logic [4:0] a;
        logic [2:0] opTable [6];
        opTable = '{OP_SET_BP, OP_HALT, OP_RD_PC, OP_WR_PC, OP_RD_REG, OP_WR_REG};
        for (int i = 0; i < count; i++) begin
            op = opTable[$urandom_range(0, 5)];
            a  = 5'($urandom_range(0, 31));
            wd = $urandom;
            expData = '0;
            case (op)
                OP_RD_PC:  expData = expPc;
                OP_RD_REG: expData = expRf[a];
                OP_WR_PC:  expPc = wd;
                OP_WR_REG: if (a != 5'd0) expRf[a] = wd;
                default:   expData = '0;
            endcase
            send_cmd(op, a, wd, $urandom_range(0, 3), d, e, t);
            checks++;
            if ({t, e, d} !== {2'b00, expData}) begin
                failures++; $display("[TB] FAIL rand_op%0d_iter%0d: got to=%b err=%b data=%h want 0 0 %h", op, i, t, e, d, expData);
            end
            checks++;
            if (dbgHalted !== 1'b1) begin
                failures++; $display("[TB] FAIL rand_halted_iter%0d: got %b want 1", i, dbgHalted);
            end
        end
    endtask

    task automatic test_step();
        logic [31:0] d; logic e, t;
        send_cmd(OP_WR_PC, 5'd0, 32'h100, 0, d, e, t);
        @(negedge clk);
        checks++;
        if ({t, e, modelPc} !== {2'b00, 32'h100}) begin
            failures++; $display("[TB] FAIL wr_pc: got to=%b err=%b pc=%h want 0 0 00000100", t, e, modelPc);
        end
        autoMode = 1'b0; manIdle = 1'b1; manPc = 32'h100;
        cmdValid = 1'b1; cmdOp = OP_STEP; cmdAddr = '0; cmdWdata = '0;
        @(negedge clk);
        cmdValid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({cmPcStall, rspValid} !== 2'b00) begin
                failures++; $display("[TB] FAIL step_rel_%0d: got stall=%b rv=%b want 0 0", k, cmPcStall, rspValid);
            end
            @(negedge clk);
        end
        manIdle = 1'b0;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if ({cmPcStall, rspValid, dbgHalted} !== 3'b100) begin
                failures++; $display("[TB] FAIL step_wait: got stall=%b rv=%b halted=%b want 1 0 0", cmPcStall, rspValid, dbgHalted);
            end
        end
        manIdle = 1'b1; manPc = 32'h104;
        @(negedge clk);
        checks++;
        if ({rspValid, rspErr, rspData, dbgHalted, dbgCause, cmPcStall} !== {2'b10, 32'h104, 1'b1, 2'd2, 1'b1}) begin
            failures++; $display("[TB] FAIL step_done: got rv=%b err=%b data=%h halted=%b cause=%0d stall=%b want 1 0 00000104 1 2 1",
                                 rspValid, rspErr, rspData, dbgHalted, dbgCause, cmPcStall);
        end
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        autoMode = 1'b1;
    endtask

    task automatic test_breakpoint();
        logic [31:0] d; logic e, t; int n, relBase;
        send_cmd(OP_SET_BP, 5'd1, 32'h10C, 0, d, e, t);
        send_cmd(OP_WR_PC, 5'd0, 32'h100, 0, d, e, t);
        relBase = relAtBp;
        send_cmd(OP_RESUME, 5'd0, 32'd0, 0, d, e, t);
        checks++;
        if ({t, e, d} !== 34'd0) begin
            failures++; $display("[TB] FAIL resume_rsp: got to=%b err=%b data=%h want 0 0 0", t, e, d);
        end
        n = 0;
        while (!dbgHalted && n < TIMEOUT) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        checks++;
        if ({dbgHalted, dbgCause, cmPcStall, coreIdle, pcRead} !== {1'b1, 2'd3, 2'b11, 32'h10C}) begin
            failures++; $display("[TB] FAIL bp_halt: got halted=%b cause=%0d stall=%b idle=%b pc=%h want 1 3 1 1 0000010c",
                                 dbgHalted, dbgCause, cmPcStall, coreIdle, pcRead);
        end
        checks++;
        if (relAtBp !== relBase) begin
            failures++; $display("[TB] FAIL bp_released: got %0d releases at bp want 0", relAtBp - relBase);
        end
        send_cmd(OP_RESUME, 5'd0, 32'd0, 0, d, e, t);
        n = 0;
        while (pcRead != 32'h110 && n < TIMEOUT) begin @(negedge clk); n++; end
        checks++;
        if ({pcRead, dbgHalted} !== {32'h110, 1'b0}) begin
            failures++; $display("[TB] FAIL bp_resume_past: got pc=%h halted=%b want 00000110 0", pcRead, dbgHalted);
        end
        checks++;
        if (relAtBp !== relBase + 1) begin
            failures++; $display("[TB] FAIL bp_release_count: got %0d want 1", relAtBp - relBase);
        end
    endtask

    task automatic test_running_errors();
        logic [31:0] d; logic e, t; int rw, pw;
        logic [2:0] errOps [5];
        errOps = '{OP_RD_REG, OP_WR_REG, OP_RD_PC, OP_WR_PC, OP_STEP};
        rw = rfWeCnt; pw = pcWeCnt;
        foreach (errOps[i]) begin
            send_cmd(errOps[i], 5'd5, 32'hCAFE_0000, $urandom_range(0, 2), d, e, t);
            checks++;
            if ({t, e, d} !== {2'b01, 32'd0}) begin
                failures++; $display("[TB] FAIL run_err_op%0d: got to=%b err=%b data=%h want 0 1 0", errOps[i], t, e, d);
            end
        end
        send_cmd(OP_RESUME, 5'd0, 32'd0, 0, d, e, t);
        checks++;
        if ({t, e, d, dbgHalted} !== 35'd0) begin
            failures++; $display("[TB] FAIL run_resume_noop: got to=%b err=%b data=%h halted=%b want 0 0 0 0", t, e, d, dbgHalted);
        end
        send_cmd(OP_SET_BP, 5'd0, 32'd0, 0, d, e, t);
        checks++;
        if ({rfWeCnt - rw, pcWeCnt - pw} !== {32'd0, 32'd0}) begin
            failures++; $display("[TB] FAIL run_no_pulses: got rfwe=%0d pcwe=%0d want 0 0", rfWeCnt - rw, pcWeCnt - pw);
        end
    endtask

    task automatic test_halt_latency();
        @(negedge clk);
        autoMode = 1'b0; manIdle = 1'b0; manPc = 32'h200;
        cmdValid = 1'b1; cmdOp = OP_HALT; cmdAddr = '0; cmdWdata = '0;
        @(negedge clk);
        cmdValid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({rspValid, dbgHalted, cmPcStall, cmdReady} !== 4'b0010) begin
                failures++; $display("[TB] FAIL halting_%0d: got rv=%b halted=%b stall=%b crdy=%b want 0 0 1 0", k, rspValid, dbgHalted, cmPcStall, cmdReady);
            end
            @(negedge clk);
        end
        manIdle = 1'b1;
        @(negedge clk);
        checks++;
        if ({rspValid, rspErr, dbgHalted, dbgCause} !== 5'b10101) begin
            failures++; $display("[TB] FAIL halt_done: got rv=%b err=%b halted=%b cause=%0d want 1 0 1 1", rspValid, rspErr, dbgHalted, dbgCause);
        end
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        autoMode = 1'b1;
        repeat (CORE_LAT + 3) @(negedge clk);
    endtask

    task automatic test_back_pressure();
        logic [31:0] expData;
        expData = pcRead;
        cmdValid = 1'b1; cmdOp = OP_RD_PC; cmdAddr = '0; cmdWdata = '0;
        @(negedge clk);
        cmdValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({rspValid, cmdReady, rspData} !== {2'b10, expData}) begin
                failures++; $display("[TB] FAIL hold_%0d: got rv=%b crdy=%b data=%h want 1 0 %h", k, rspValid, cmdReady, rspData, expData);
            end
            if (k < 3) @(negedge clk);
        end
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        checks++;
        if ({rspValid, cmdReady} !== 2'b01) begin
            failures++; $display("[TB] FAIL hold_release: got rv=%b crdy=%b want 0 1", rspValid, cmdReady);
        end
    endtask

    task automatic test_reset_mid_op();
        autoMode = 1'b0; manIdle = 1'b1; manPc = 32'h300;
        cmdValid = 1'b1; cmdOp = OP_STEP;
        @(negedge clk);
        cmdValid = 1'b0;
        manIdle = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmPcStall, dbgHalted} !== 2'b10) begin
            failures++; $display("[TB] FAIL pre_reset_step_wait: got stall=%b halted=%b want 1 0", cmPcStall, dbgHalted);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rspValid, dbgHalted, cmPcStall, dbgCause, cmdReady, cmPcWe, cmRfWe} !== 8'b0_1_1_00_1_0_0) begin
            failures++; $display("[TB] FAIL async_reset_step: got rv=%b halted=%b stall=%b cause=%0d crdy=%b want 0 1 1 0 1",
                                 rspValid, dbgHalted, cmPcStall, dbgCause, cmdReady);
        end
        @(negedge clk);
        rst_n = 1'b1; autoMode = 1'b1;
        cmdValid = 1'b1; cmdOp = OP_RD_PC;
        @(negedge clk);
        cmdValid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rspValid, rspData} !== 33'd0) begin
            failures++; $display("[TB] FAIL async_reset_rsp: got rv=%b data=%h want 0 0", rspValid, rspData);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_reg_access();
        test_random_halted(40);
        test_step();
        test_breakpoint();
        test_running_errors();
        test_halt_latency();
        test_back_pressure();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
